// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered grant held under valid/ready.
// The winner is presented as a binary index and as its one-hot decode.
// Optional macro ARB_LOCK_EN adds a lock input. When lock is high at a
// handshake and the winner still requests, the winner keeps ownership.
//
// state | meaning
// IDLE  | no grant presented; waiting for any request
// GRANT | grant presented and frozen until gnt_valid & gnt_ready
module rr_onehot_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             gnt_ready,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic             gnt_valid,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             win_found;
    logic             any_req;
    logic             lock_hit;
    int               cand;

    assign any_req = |req;

    // Pointer after accepting the current winner. The wrap is explicit
    // so that non-power-of-two N never yields a pointer of N or above.
    assign ptr_adv = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

    // A back-to-back selection in GRANT must already see the advanced pointer.
    assign base = (state_q == GRANT) ? ptr_adv : ptr_q;

`ifdef ARB_LOCK_EN
    assign lock_hit = lock & req[idx_q];
`else
    assign lock_hit = 1'b0;
`endif

    // Winner search in the order base, base+1, ..., N-1, 0, ..., base-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(base) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state, pointer and grant index selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                end
            end
            GRANT: begin
                if (gnt_ready && !lock_hit) begin
                    ptr_d = ptr_adv;
                    if (any_req) begin
                        idx_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    // The index register is cleared whenever the FSM returns to IDLE.
    // Gating with gnt_valid keeps the one-hot vector zero even so.
    always_comb begin
        gnt_onehot = '0;
        if (gnt_valid) gnt_onehot[idx_q] = 1'b1;
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic [3:0] req4 = '0;
    logic       rdy4 = 1'b0;
    logic       lock4 = 1'b0;
    logic       gnt_valid4;
    logic [3:0] gnt_onehot4;
    logic [1:0] gnt_idx4;

    logic [4:0] req5 = '0;
    logic       rdy5 = 1'b0;
    logic       lock5 = 1'b0;
    logic       gnt_valid5;
    logic [4:0] gnt_onehot5;
    logic [2:0] gnt_idx5;

    int n_checks = 0;
    int n_pass   = 0;

    int q4[$];
    int q5[$];

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N(4)) u4 (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req4),
        .gnt_ready  (rdy4),
`ifdef ARB_LOCK_EN
        .lock       (lock4),
`endif
        .gnt_valid  (gnt_valid4),
        .gnt_onehot (gnt_onehot4),
        .gnt_idx    (gnt_idx4)
    );

    rr_onehot_arbiter #(.N(5)) u5 (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req5),
        .gnt_ready  (rdy5),
`ifdef ARB_LOCK_EN
        .lock       (lock5),
`endif
        .gnt_valid  (gnt_valid5),
        .gnt_onehot (gnt_onehot5),
        .gnt_idx    (gnt_idx5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One isolated grant from IDLE: checks first-grant latency, then the
    // handshake returns the FSM to IDLE because req has dropped.
    task automatic grant_once(input logic [3:0] r, input int e);
        req4 = r;
        rdy4 = 1'b1;
        q4.push_back(e);
        cyc();
        check("first_latency_valid", gnt_valid4, 1);
        check("first_latency_idx", gnt_idx4, e);
        req4 = '0;
        cyc();
        check("return_idle", gnt_valid4, 0);
    endtask

    // Scoreboard monitors: every accepted grant must match the next expected one.
    always @(negedge clk) begin
        logic [3:0] oh;
        int e;
        if (gnt_valid4 && rdy4) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL grant4_unexpected: got idx %0d, expected no grant at %0t", gnt_idx4, $time);
            end else begin
                e  = q4.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                check("grant4_idx", gnt_idx4, e);
                check("grant4_onehot", gnt_onehot4, oh);
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] oh;
        int e;
        if (gnt_valid5 && rdy5) begin
            if (q5.size() == 0) begin
                n_checks++;
                $display("FAIL grant5_unexpected: got idx %0d, expected no grant at %0t", gnt_idx5, $time);
            end else begin
                e  = q5.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                check("grant5_idx", gnt_idx5, e);
                check("grant5_onehot", gnt_onehot5, oh);
            end
        end
    end

    initial begin
        // Reset held with arbitrary requests.
        for (int i = 0; i < 3; i++) begin
            req4 = 4'($urandom_range(1, 15));
            req5 = 5'($urandom_range(1, 31));
            rdy4 = 1'($urandom_range(0, 1));
            cyc();
            check("reset_valid", gnt_valid4, 0);
            check("reset_onehot", gnt_onehot4, 0);
            check("reset_idx", gnt_idx4, 0);
        end
        check("reset_valid5", gnt_valid5, 0);
        req4 = '0;
        req5 = '0;
        rdy4 = 1'b0;
        resetn = 1'b1;
        repeat (3) cyc();
        check("idle_after_reset_valid", gnt_valid4, 0);
        check("idle_after_reset_onehot", gnt_onehot4, 0);

        // Rotation between requesters 1 and 2 with no bubbles.
        req4 = 4'b0110;
        rdy4 = 1'b1;
        q4.push_back(1); q4.push_back(2); q4.push_back(1);
        q4.push_back(2); q4.push_back(1); q4.push_back(2);
        repeat (6) cyc();
        req4 = '0;
        cyc();
        check("rotation_all_served", q4.size(), 0);
        check("rotation_idle", gnt_valid4, 0);

        // Backpressure: pointer is 3, grant idx3 held while req changes.
        rdy4 = 1'b0;
        req4 = 4'b1000;
        cyc();
        req4 = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", gnt_valid4, 1);
            check("hold_idx", gnt_idx4, 3);
            check("hold_onehot", gnt_onehot4, 4'b1000);
            cyc();
        end
        q4.push_back(3);
        q4.push_back(0);
        rdy4 = 1'b1;
        cyc();
        req4 = '0;
        cyc();
        check("backpressure_all_served", q4.size(), 0);

        // Async reset mid-grant: pointer is 1, so req 0100 wins idx2.
        rdy4 = 1'b0;
        req4 = 4'b0100;
        cyc();
        check("pre_reset_valid", gnt_valid4, 1);
        check("pre_reset_idx", gnt_idx4, 2);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_valid", gnt_valid4, 0);
        check("async_reset_onehot", gnt_onehot4, 0);
        check("async_reset_idx", gnt_idx4, 0);
        #1 resetn = 1'b1;
        // Pointer back at 0: 0011 picks idx0 (stale pointer 1 would pick idx1).
        grant_once(4'b0011, 0);
        grant_once(4'b0100, 2);

        // Non-power-of-two wrap on N=5.
        req5 = 5'b01000;
        rdy5 = 1'b1;
        q5.push_back(3);
        cyc();
        req5 = 5'b10001;
        q5.push_back(4);
        q5.push_back(0);
        cyc();
        cyc();
        req5 = '0;
        cyc();
        check("wrap_all_served", q5.size(), 0);
        check("wrap_idle", gnt_valid5, 0);
        rdy5 = 1'b0;

`ifdef ARB_LOCK_EN
        // Lock: pointer is 3; 0011 wins idx0, which is kept while locked.
        req4 = 4'b0011;
        lock4 = 1'b1;
        rdy4 = 1'b1;
        q4.push_back(0); q4.push_back(0); q4.push_back(0); q4.push_back(1);
        cyc();
        cyc();
        cyc();
        lock4 = 1'b0;
        cyc();
        req4 = '0;
        cyc();
        check("lock_all_served", q4.size(), 0);
        check("lock_idle", gnt_valid4, 0);
`endif

        rdy4 = 1'b0;
        repeat (2) cyc();
        check("final_q4_empty", q4.size(), 0);
        check("final_q5_empty", q5.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
